median_seq: RTL and testbench

//  Sequencer that feeds a MED sorting column and returns the median of each
//  P-pixel window. Gathers pixels (gaps allowed) into a P-entry buffer, then

---
 rtl/median_seq.sv | 158 +++++++++++++++
 tb/tb_median_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/median_seq.sv
// median_seq -- feeds a ring-shaped MED sorting column and returns the median
// of each P-pixel window.
//
// Pixels are gathered (gaps allowed) into a P-entry collect buffer. A full
// buffer is copied to a shadow buffer, which frees the collect buffer for the
// next window while the current one is processed. The shadow is then streamed
// into the MED column through these phases:
//   XFER : shift the P shadow pixels in.
//   SCAN : rotate P-1 times; the last stage keeps the running max.
//   DROP : shift a 0 in, pushing the max out. The ring stays P entries.
// After (P-1)/2 drops, one more SCAN leaves the median in the last stage.
//
// Optional feature: define MEDIAN_MAX_EN to add MAXO. MAXO is the window max,
// latched at the end of the first SCAN. It updates on the same edge as DO.
//
// Parameters: W pixel width, P window size (odd, >= 3)
// Ports:
//   CLK   in      clock, posedge
//   nRST  in      asynchronous active-low reset
//   DI    in  W   input pixel
//   DSI   in      DI valid, accepted only when RDY=1
//   RDY   out     collect buffer not full
//   DO    out W   median of the last window, held until the next result
//   DSO   out     one-cycle pulse marking a new DO
//   MAXO  out W   window max (MEDIAN_MAX_EN only)
module median_seq #(
  parameter int W = 8,
  parameter int P = 9
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic [W-1:0] DI,
  input  logic         DSI,
  output logic         RDY,
  output logic [W-1:0] DO,
`ifdef MEDIAN_MAX_EN
  output logic [W-1:0] MAXO,
`endif
  output logic         DSO
);

  if (P < 3 || (P % 2) == 0) begin : g_bad_p
    $error("median_seq: P must be odd and >= 3");
  end

  localparam int CW = $clog2(P + 1);
  localparam int PW = $clog2(P);
  localparam logic [CW-1:0] CNT_FULL = CW'(P);
  localparam logic [CW-1:0] XFER_END = CW'(P - 1);
  localparam logic [CW-1:0] SCAN_END = CW'(P - 2);
  localparam logic [PW-1:0] DROPS    = PW'((P - 1) / 2);

  typedef enum logic [2:0] {IDLE, XFER, SCAN, DROP, DONE} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt, cyc;
  logic [PW-1:0]       pass;
  logic [P-1:0][W-1:0] col_buf, shadow, ring;
  logic [W-1:0]        med_di, hi, lo;
  logic                med_dsi, med_byp, accept, load, scan_last;

  assign RDY       = (cnt != CNT_FULL);
  assign accept    = DSI & RDY;
  // A full buffer is handed to the shadow only when the column is free.
  assign load      = (cnt == CNT_FULL) && (state == IDLE || state == DONE);
  assign scan_last = (state == SCAN) && (cyc == SCAN_END);

  // ---------------- collect / shadow ----------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)       cnt <= '0;
    else if (load)   cnt <= '0;
    else if (accept) cnt <= cnt + CW'(1);
  end

  always_ff @(posedge CLK) begin
    if (accept) col_buf[cnt] <= DI;
    if (load)   shadow <= col_buf;
  end

  // ---------------- MED column ----------------
  // ring[P-1] is the last stage. In SCAN it keeps the larger of itself and
  // its neighbour; the smaller value wraps to ring[0], so the set of values
  // in the ring never changes.
  assign hi = (ring[P-1] >= ring[P-2]) ? ring[P-1] : ring[P-2];
  assign lo = (ring[P-1] >= ring[P-2]) ? ring[P-2] : ring[P-1];

  always_ff @(posedge CLK) begin
    if (med_dsi && med_byp)        ring <= {ring[P-2:0], med_di};
    else if (!med_dsi && !med_byp) ring <= {hi, ring[P-3:0], lo};
  end

  // ---------------- sequencer ----------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      cyc   <= '0;
      pass  <= '0;
    end else begin
      state <= state_nxt;
      // cyc restarts on every state change and only runs in timed states.
      if (state_nxt != state)                   cyc <= '0;
      else if (state == XFER || state == SCAN)  cyc <= cyc + CW'(1);
      // pass counts drops within one window, so it restarts per window.
      if (state_nxt == XFER && state != XFER)   pass <= '0;
      else if (scan_last && pass < DROPS)       pass <= pass + PW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    med_dsi   = 1'b0;
    med_byp   = 1'b0;
    med_di    = '0;
    case (state)
      IDLE: if (cnt == CNT_FULL) state_nxt = XFER;
      XFER: begin
        med_dsi = 1'b1;
        med_byp = 1'b1;
        med_di  = shadow[cyc];
        if (cyc == XFER_END) state_nxt = SCAN;
      end
      SCAN: if (scan_last) state_nxt = (pass < DROPS) ? DROP : DONE;
      DROP: begin
        med_dsi   = 1'b1;
        med_byp   = 1'b1;
        state_nxt = SCAN;
      end
      DONE:    state_nxt = (cnt == CNT_FULL) ? XFER : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- result ----------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      DO  <= '0;
      DSO <= 1'b0;
    end else begin
      DSO <= (state == DONE);
      if (state == DONE) DO <= ring[P-1];
    end
  end

`ifdef MEDIAN_MAX_EN
  logic [W-1:0] max_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      max_q <= '0;
      MAXO  <= '0;
    end else begin
      if (scan_last && pass == '0) max_q <= hi;
      if (state == DONE)           MAXO  <= max_q;
    end
  end
`endif

endmodule

// File: tb/tb_median_seq.sv
module tb_median_seq;
  localparam int W = 8;
  localparam int P = 9;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] di = '0;
  logic         dsi = 1'b0;
  logic         rdy, dso;
  logic [W-1:0] dout;
`ifdef MEDIAN_MAX_EN
  logic [W-1:0] maxo;
`endif

  median_seq #(.W(W), .P(P)) dut (
    .CLK(clk), .nRST(rst_n), .DI(di), .DSI(dsi), .RDY(rdy), .DO(dout),
`ifdef MEDIAN_MAX_EN
    .MAXO(maxo),
`endif
    .DSO(dso)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    int med;
    int mx;
  } exp_t;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  int   win[$];
  int   dso_cyc[$];
  int   acc_cyc = 0;

  // Reference: sort the window; median is the middle element, max the last.
  function automatic exp_t ref_window(input int px[$]);
    int   s[$];
    exp_t e;
    s = px;
    s.sort();
    e.med = s[P/2];
    e.mx  = s[P-1];
    return e;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every DSO pulse must match the oldest outstanding window.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && dso) begin
      dso_cyc.push_back(cyc_cnt);
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_dso: got DO=%0d, expected no pulse", dout);
      end else begin
        e = exp_q.pop_front();
        check("median", int'(dout), e.med);
`ifdef MEDIAN_MAX_EN
        check("maxo", int'(maxo), e.mx);
`endif
      end
    end
  end

  // Offer one pixel, holding DSI high until the DUT accepts it.
  task automatic send(input int v);
    int b;
    b = 0;
    @(negedge clk);
    di  = v[W-1:0];
    dsi = 1'b1;
    while (!rdy && b < 200) begin
      @(negedge clk);
      b++;
    end
    if (!rdy) begin
      check("rdy_timeout", 0, 1);
      dsi = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc_cnt;
    win.push_back(v);
    if (win.size() == P) begin
      exp_q.push_back(ref_window(win));
      win.delete();
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    dsi = 1'b0;
    di  = 8'hAA;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (exp_q.size() > 0 && b < 400) begin
      @(negedge clk);
      b++;
    end
    repeat (3) @(negedge clk);
    check("drain_outstanding", exp_q.size(), 0);
  endtask

  // Asynchronous reset between edges; outputs must clear before the next edge.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    dsi   = 1'b0;
    #1;
    check("rst_rdy", int'(rdy), 1);
    check("rst_dso", int'(dso), 0);
    check("rst_do", int'(dout), 0);
`ifdef MEDIAN_MAX_EN
    check("rst_maxo", int'(maxo), 0);
`endif
    win.delete();
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int w3[$];
    int mode, v;
    w3 = '{255, 0, 255, 0, 255, 0, 255, 0, 7};

    // reset state before any clock edge
    #3;
    check("init_rdy", int'(rdy), 1);
    check("init_dso", int'(dso), 0);
    check("init_do", int'(dout), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // gapless 1..9, latency from last accept
    for (int i = 1; i <= P; i++) send(i);
    idle(1);
    drain();
    if (dso_cyc.size() > 0) check("latency", dso_cyc[dso_cyc.size()-1] - acc_cyc, 55);
    else check("latency_no_dso", 0, 1);
    check("single_pulse", dso_cyc.size(), 1);

    // extreme values, then all-equal
    foreach (w3[i]) send(w3[i]);
    idle(1);
    for (int i = 0; i < P; i++) send(200);
    idle(1);
    drain();

    // 9..1 with DSI every third cycle
    for (int i = P; i >= 1; i--) begin
      send(i);
      idle(2);
    end
    drain();

    // 18 back-to-back pixels: second window waits on RDY
    dso_cyc.delete();
    for (int i = 0; i < 2 * P; i++) send($urandom_range(0, 255));
    @(negedge clk);
    check("rdy_low_full", int'(rdy), 0);
    dsi = 1'b1;
    di  = 8'h00;          // offered while RDY=0, must not be stored
    repeat (5) @(negedge clk);
    idle(1);
    drain();
    if (dso_cyc.size() == 2) check("dso_spacing", dso_cyc[1] - dso_cyc[0], 54);
    else check("dso_count_b2b", dso_cyc.size(), 2);

    // reset mid-SCAN with a partial next window collected
    for (int i = 0; i < P; i++) send($urandom_range(0, 255));
    for (int i = 0; i < 4; i++) send($urandom_range(0, 255));
    idle(8);
    do_reset();
    repeat (80) @(negedge clk);
    foreach (w3[i]) w3[i] = 0;
    w3 = '{3, 1, 4, 1, 5, 9, 2, 6, 5};
    foreach (w3[i]) send(w3[i]);
    idle(1);
    drain();

    // randomized windows with random gaps and value distributions
    for (int w = 0; w < 14; w++) begin
      mode = $urandom_range(0, 2);
      for (int i = 0; i < P; i++) begin
        case (mode)
          0:       v = $urandom_range(0, 255);
          1:       v = $urandom_range(0, 3);
          default: v = ($urandom_range(0, 1) != 0) ? 255 : 0;
        endcase
        send(v);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
    end
    idle(1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
